// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared types and constants for the tinyalu requester
//
// Contents:
//   op_t         : ALU operation encoding (1xx decodes as multiply in the ALU)
//   req_state_t  : requester FSM state encoding
//   TIMEOUT_RESULT : result returned when an operation is aborted by timeout
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_ISSUE = 2'd1,
    REQ_RESP  = 2'd2
  } req_state_t;

  localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

endpackage

// File: rtl/tinyalu_requester.sv
// rtl/tinyalu_requester.sv - initiator side of the tinyalu start/done handshake
//
// Accepts one command at a time on a valid/ready stream, drives it into a
// tinyalu-style responder, holds alu_start until alu_done, and returns the
// captured result on a valid/ready response stream.
//
// Optional build macro: TINYALU_REQ_TIMEOUT_EN
//   Defined   : ISSUE is aborted after TIMEOUT_CYCLES edges without alu_done;
//               the response carries rsp_err=1 and rsp_result=16'hDEAD.
//   Undefined : no watchdog, rsp_err is constant 0, ISSUE waits indefinitely.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op[2:0], cmd_a/cmd_b[7:0]   command operation and operands
//   alu_a/alu_b[7:0], alu_op[2:0]   operands/op to the ALU (held until next accept)
//   alu_start / alu_done            start request / completion from the ALU
//   alu_result[15:0]                result from the ALU
//   rsp_valid/rsp_ready             response handshake
//   rsp_result[15:0], rsp_op[2:0]   captured result and op of the response
//   rsp_err                         response is a timeout abort
//   busy                            FSM not idle
module tinyalu_requester
  import tinyalu_pkg::*;
`ifdef TINYALU_REQ_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] IDLE  = REQ_IDLE;
  localparam logic [1:0] ISSUE = REQ_ISSUE;
  localparam logic [1:0] RESP  = REQ_RESP;

  logic [1:0] state;

`ifdef TINYALU_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_count;
  logic          wd_expired;
  logic          err_q;

  // wd_count holds the number of ISSUE edges already seen without done, so
  // the edge that would make it TIMEOUT_CYCLES is the abort edge.
  assign wd_expired = (wd_count == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

  // A done still high while idle is stale (or a duplicate); taking a new
  // command then would let the ALU's old done complete the new operation.
  assign cmd_ready = reset_n && (state == IDLE) && !alu_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      busy       <= 1'b0;
`ifdef TINYALU_REQ_TIMEOUT_EN
      wd_count   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
            rsp_op <= cmd_op;
            busy   <= 1'b1;
            if (cmd_op == NO_OP) begin
              // nop never touches the ALU; answer directly
              rsp_result <= '0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
`ifdef TINYALU_REQ_TIMEOUT_EN
              err_q      <= 1'b0;
`endif
            end else begin
              alu_start <= 1'b1;
              state     <= ISSUE;
`ifdef TINYALU_REQ_TIMEOUT_EN
              wd_count  <= '0;
`endif
            end
          end
        end

        ISSUE: begin
          // done has priority over a timeout on the same edge
          if (alu_done) begin
            rsp_result <= alu_result;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
`ifdef TINYALU_REQ_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (wd_expired) begin
            rsp_result <= TIMEOUT_RESULT;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            err_q      <= 1'b1;
            state      <= RESP;
          end else begin
            wd_count   <= wd_count + 1'b1;
`endif
          end
        end

        RESP: begin
          // alu_done is deliberately ignored here
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          alu_start <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tinyalu_requester.md
Name: tinyalu_requester

Overview:
Initiator side of the ALU start/done handshake. It accepts operation commands on a valid/ready stream and drives A/B/op/start into a tinyalu-style responder. It holds start until done is observed, captures the 16-bit result, and returns it on a valid/ready response stream. It sits between a command source (bus bridge or test sequencer) and the ALU. At most one operation is outstanding at a time.

Parameters:
TIMEOUT_CYCLES, 16, number of ISSUE-state clock edges without alu_done before the operation is aborted (used only with the optional feature).

Ports:
clk  input  1  clock
reset_n  input  1  synchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted on a cycle where cmd_valid && cmd_ready
cmd_op  input  3  operation: 000 nop, 001 add, 010 and, 011 xor, 1xx mul
cmd_a  input  8  operand A
cmd_b  input  8  operand B
alu_a  output  8  operand A to ALU
alu_b  output  8  operand B to ALU
alu_op  output  3  operation to ALU
alu_start  output  1  start request to ALU
alu_done  input  1  completion from ALU
alu_result  input  16  result from ALU
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed on a cycle where rsp_valid && rsp_ready
rsp_result  output  16  captured result
rsp_op  output  3  op of the response
rsp_err  output  1  response is a timeout abort
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: clk, rising edge; reset reset_n is synchronous and active-low.
- Reset values: all outputs 0, state IDLE; this includes cmd_ready, alu_*, rsp_*, and busy.
- Reset mid-operation: the FSM returns to IDLE and alu_start drops on the next edge. The ALU is reset by the same signal.
- All outputs are registered except cmd_ready.
- cmd_ready = (state==IDLE) && !alu_done. A new command is blocked while a stale or duplicate done is still high.
- The FSM has three states: IDLE, ISSUE, RESP.
- IDLE, on accept:
  - Register alu_a, alu_b, alu_op and rsp_op from the command.
  - If op==000, go to RESP with rsp_result=0 and rsp_err=0. alu_start is never asserted for a nop.
  - Otherwise go to ISSUE with alu_start=1.
- ISSUE:
  - alu_start stays 1.
  - On the edge where alu_done is sampled 1: rsp_result<=alu_result, rsp_err<=0, alu_start<=0, go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_result, rsp_op and rsp_err stay stable until the handshake.
  - On the handshake, go to IDLE.
  - alu_done is ignored in RESP.
- alu_a, alu_b and alu_op stay stable from accept until the next accept, including RESP and IDLE. This matters because the ALU's done/result mux depends on op.
- Latency, counted from the accept edge to rsp_valid high (rsp_ready=1):
  - add/and/xor: 2 cycles.
  - mul: 5 cycles.
  - nop: 1 cycle.
- Throughput: the next accept happens at the earliest 1 cycle after the response handshake, and only once alu_done is sampled low.
- op 101..111 are forwarded unchanged and are treated as mul by the ALU.

Optional Feature:
TINYALU_REQ_TIMEOUT_EN
- With the macro:
  - A counter clears on entry to ISSUE and increments on each ISSUE edge without done.
  - When the count reaches TIMEOUT_CYCLES, on that edge: alu_start<=0, rsp_result<=16'hDEAD, rsp_err<=1, go to RESP.
  - If done and timeout occur on the same edge, done wins.
- Without the macro: no counter is built, rsp_err is tied to 0, and ISSUE waits indefinitely.

Decomposition:
- Shared package tinyalu_pkg:
  - typedef enum logic[2:0] op_t {NO_OP=3'b000, ADD=3'b001, AND=3'b010, XOR=3'b011, MUL=3'b100}.
  - Requester state enum.
  - Constant TIMEOUT_RESULT=16'hDEAD.
- No sub-module is required. The watchdog can be split out as tinyalu_req_watchdog (counter + expired flag) if reused.

Test Plan:
- add: cmd A=8'hFF, B=8'h01, op=001 -> rsp_result=16'h0100 and rsp_valid 2 cycles after accept. alu_start is high for exactly 2 cycles.
- mul: A=8'hFF, B=8'hFF, op=100 -> rsp_result=16'hFE01 5 cycles after accept. alu_a, alu_b and alu_op are stable throughout.
- nop: op=000 with A=8'h12, B=8'h34 -> rsp_result=0 after 1 cycle. alu_start never goes high.
- Backpressure: rsp_ready=0 for 10 cycles after an xor of 8'hF0, 8'h3C -> rsp_result is held at 16'h00CC, cmd_ready=0 and busy=1. The next command is accepted only after the handshake and once alu_done is low.
- Reset mid-mul: reset_n is taken low 2 cycles after accept -> all outputs return to 0. A following add of 8'h02+8'h03 -> 16'h0005.
- Timeout (macro on, TIMEOUT_CYCLES=16): alu_done forced 0 -> alu_start drops 16 edges after entering ISSUE. The response is rsp_err=1, rsp_result=16'hDEAD.
